// File: rtl/fibonacci_stream_if.sv
// ---------------------------------------------------------------------------
// fibonacci_stream_if
// Output stream of the Fibonacci generator: one group of LANES terms per beat.
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid is raised, out_data is held stable
// and out_valid stays high until the beat transfers. The one exception is a
// restart of the producer, which may replace a pending group. out_valid never
// depends combinationally on out_ready.
//
// Signals
//   out_valid : master -> slave, out_data holds a valid group
//   out_ready : slave -> master, the slave accepts the group
//   out_data  : master -> slave, lane i in bits [i*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
interface fibonacci_stream_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 2
);
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/fibonacci_stream.sv
// ---------------------------------------------------------------------------
// fibonacci_stream
// Seedable Fibonacci generator that emits LANES consecutive terms per beat on
// a valid/ready stream. The stream stops after the last group whose terms all
// fit in WIDTH bits, and it raises a sticky overflow flag at that point.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous, active-high reset
//   start       : single-cycle pulse; loads the seeds and (re)starts
//   seed_a      : term t0, sampled when start=1
//   seed_b      : term t1, sampled when start=1
//   out         : stream master (out_valid / out_ready / out_data)
//   overflow    : sticky; the next term does not fit in WIDTH bits
//   done        : the generator has stopped in DONE
//   dbg_state_o : current FSM state (0=IDLE, 1=RUN, 2=DONE)
// ---------------------------------------------------------------------------
module fibonacci_stream #(
  parameter int WIDTH = 16,
  parameter int LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     seed_a,
  input  logic [WIDTH-1:0]     seed_b,
  fibonacci_stream_if.master   out,
  output logic                 overflow,
  output logic                 done,
  output logic [1:0]           dbg_state_o
);

  if (LANES < 1 || LANES > 4) begin : g_bad_lanes
    $error("fibonacci_stream: LANES must be in 1..4");
  end

  // Size of the seed-expansion array: the group-0 terms, but never fewer
  // than the two seeds.
  localparam int SN = (LANES < 2) ? 2 : LANES;
  // Index of the second-to-last lane (only meaningful for LANES >= 2).
  localparam int LO_IDX = (LANES > 1) ? LANES - 2 : 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [LANES*WIDTH-1:0] data_q,  data_d;
  logic                   ovf_q,   ovf_d;
  logic                   done_q,  done_d;
  // Last two terms of the current group: last_q is the final lane, prev_q
  // the one before it.
  logic [WIDTH-1:0]       last_q,  last_d;
  logic [WIDTH-1:0]       prev_q,  prev_d;
  // With LANES=1 group 0 is seed_a alone, and the next term is seed_b
  // rather than a sum. pend_q marks that case, and prev_q then holds seed_b.
  logic                   pend_q,  pend_d;

  // Candidate terms at WIDTH+1 bits. A group is illegal if any candidate has
  // bit WIDTH set. Each sum only wraps at WIDTH+1 bits after an earlier
  // candidate has already overflowed, so the first overflowing term is always
  // detected correctly.
  logic [WIDTH:0]         ext_s [SN];
  logic [WIDTH:0]         ext_n [LANES+2];
  logic [WIDTH:0]         cand  [LANES];
  logic [LANES*WIDTH-1:0] grp0_data;
  logic [LANES*WIDTH-1:0] next_data;
  logic                   grp0_legal;
  logic                   next_legal;

  // Group 0 is the seeds followed by their running sums.
  always_comb begin
    ext_s[0] = {1'b0, seed_a};
    ext_s[1] = {1'b0, seed_b};
    for (int k = 2; k < SN; k++) begin
      ext_s[k] = ext_s[k-1] + ext_s[k-2];
    end
    grp0_data  = '0;
    grp0_legal = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      grp0_data[k*WIDTH +: WIDTH] = ext_s[k][WIDTH-1:0];
      if (ext_s[k][WIDTH]) grp0_legal = 1'b0;
    end
  end

  // The next group continues the sequence from the stored last two terms.
  always_comb begin
    ext_n[0] = {1'b0, prev_q};
    ext_n[1] = {1'b0, last_q};
    for (int k = 2; k < LANES + 2; k++) begin
      ext_n[k] = ext_n[k-1] + ext_n[k-2];
    end
    next_data  = '0;
    next_legal = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      if (LANES == 1 && pend_q) cand[k] = ext_n[0];
      else                      cand[k] = ext_n[k+2];
      next_data[k*WIDTH +: WIDTH] = cand[k][WIDTH-1:0];
      if (cand[k][WIDTH]) next_legal = 1'b0;
    end
  end

  // Next-state and output logic. Every output comes from a register.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    last_d  = last_q;
    prev_d  = prev_q;
    pend_d  = pend_q;

    if (start) begin
      // A restart overrides any pending group or a handshake in this cycle.
      ovf_d  = 1'b0;
      done_d = 1'b0;
      if (grp0_legal) begin
        state_d = ST_RUN;
        valid_d = 1'b1;
        data_d  = grp0_data;
        if (LANES == 1) begin
          last_d = seed_a;
          prev_d = seed_b;
          pend_d = 1'b1;
        end else begin
          last_d = ext_s[LANES-1][WIDTH-1:0];
          prev_d = ext_s[LO_IDX][WIDTH-1:0];
          pend_d = 1'b0;
        end
      end else begin
        state_d = ST_DONE;
        valid_d = 1'b0;
        ovf_d   = 1'b1;
        done_d  = 1'b1;
        pend_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (valid_q && out.out_ready) begin
            if (next_legal) begin
              data_d = next_data;
              pend_d = 1'b0;
              if (LANES == 1) begin
                prev_d = last_q;
                last_d = cand[0][WIDTH-1:0];
              end else begin
                last_d = cand[LANES-1][WIDTH-1:0];
                prev_d = cand[LO_IDX][WIDTH-1:0];
              end
            end else begin
              // The group just accepted was the final legal one. out_data
              // keeps it.
              state_d = ST_DONE;
              valid_d = 1'b0;
              ovf_d   = 1'b1;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE hold everything until the next start.
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= '0;
      prev_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      last_q  <= last_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
    end
  end

  assign out.out_valid = valid_q;
  assign out.out_data  = data_q;
  assign overflow      = ovf_q;
  assign done          = done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fibonacci_stream.sv
// ---------------------------------------------------------------------------
// tb_fibonacci_stream
// Runs three generators side by side (LANES = 1, 2, 4, WIDTH = 16). They share
// start, the seeds and the reset, and each has its own out_ready. A reference
// model computes the expected groups for each instance when start is driven.
// A negedge monitor pops those groups as beats transfer and checks that
// stalled beats hold.
// ---------------------------------------------------------------------------
module tb_fibonacci_stream;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [W-1:0]  seed_a;
  logic [W-1:0]  seed_b;
  logic          rdy [3];
  logic          vld [3];
  logic          ovf [3];
  logic          dn  [3];
  logic [1:0]    st  [3];
  logic [63:0]   dat [3];

  fibonacci_stream_if #(.WIDTH(W), .LANES(1)) if1 ();
  fibonacci_stream_if #(.WIDTH(W), .LANES(2)) if2 ();
  fibonacci_stream_if #(.WIDTH(W), .LANES(4)) if4 ();

  fibonacci_stream #(.WIDTH(W), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .seed_a(seed_a), .seed_b(seed_b),
    .out(if1), .overflow(ovf[0]), .done(dn[0]), .dbg_state_o(st[0]));
  fibonacci_stream #(.WIDTH(W), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .seed_a(seed_a), .seed_b(seed_b),
    .out(if2), .overflow(ovf[1]), .done(dn[1]), .dbg_state_o(st[1]));
  fibonacci_stream #(.WIDTH(W), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .seed_a(seed_a), .seed_b(seed_b),
    .out(if4), .overflow(ovf[2]), .done(dn[2]), .dbg_state_o(st[2]));

  assign if1.out_ready = rdy[0];
  assign if2.out_ready = rdy[1];
  assign if4.out_ready = rdy[2];
  assign vld[0] = if1.out_valid;
  assign vld[1] = if2.out_valid;
  assign vld[2] = if4.out_valid;
  assign dat[0] = 64'(if1.out_data);
  assign dat[1] = 64'(if2.out_data);
  assign dat[2] = 64'(if4.out_data);

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q  [3][$];
  logic [63:0] next_q [3][$];
  logic [63:0] g0_exp   [3];
  bit          g0_legal [3];
  bit          stall    [3];
  logic [63:0] held     [3];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int lanes_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expand the sequence and cut it into groups. Stop at the
  // first group that has a term of WIDTH+1 bits or more. The cap of 40 groups
  // only matters for all-zero seeds.
  task automatic build(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned t [0:199];
    int l;
    bit ok;
    logic [63:0] g;
    l = lanes_of(i);
    t[0] = 64'(a);
    t[1] = 64'(b);
    for (int n = 2; n < 200; n++) t[n] = t[n-1] + t[n-2];
    next_q[i] = {};
    for (int gi = 0; gi < 40; gi++) begin
      ok = 1'b1;
      g  = '0;
      for (int k = 0; k < l; k++) begin
        if (t[gi*l+k] >= 64'd65536) ok = 1'b0;
        g[k*W +: W] = t[gi*l+k][W-1:0];
      end
      if (!ok) break;
      next_q[i].push_back(g);
    end
    g0_legal[i] = (next_q[i].size() > 0);
    g0_exp[i]   = g0_legal[i] ? next_q[i][0] : 64'd0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) stall[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stall[i]) begin
          check_eq($sformatf("hold_valid_L%0d", lanes_of(i)), 64'(vld[i]), 64'd1);
          check_eq($sformatf("hold_data_L%0d", lanes_of(i)), dat[i], held[i]);
        end
        if (vld[i] && rdy[i]) begin
          check_eq($sformatf("beat_expected_L%0d", lanes_of(i)),
                   64'(exp_q[i].size() != 0), 64'd1);
          if (exp_q[i].size() != 0)
            check_eq($sformatf("beat_data_L%0d", lanes_of(i)), dat[i],
                     exp_q[i].pop_front());
        end
        stall[i] = vld[i] && !rdy[i] && !start;
        held[i]  = dat[i];
        if (start) exp_q[i] = next_q[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: ready always 1; mode 1: random ready; mode 2: ready 0 for the
  // first 5 cycles after start, then 1.
  task automatic set_ready(input int mode, input int n);
    for (int i = 0; i < 3; i++) begin
      if (mode == 0)      rdy[i] = 1'b1;
      else if (mode == 1) rdy[i] = 1'($urandom_range(0, 1));
      else                rdy[i] = (n >= 5);
    end
  endtask

  task automatic run_seq(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int mode, input int max_cyc, input bit full);
    int n;
    for (int i = 0; i < 3; i++) build(i, a, b);
    @(posedge clk); #1;
    seed_a = a;
    seed_b = b;
    start  = 1'b1;
    set_ready(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    // One cycle after start: group 0, or DONE if group 0 already overflows.
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("start_valid_L%0d", lanes_of(i)), 64'(vld[i]), 64'(g0_legal[i]));
      check_eq($sformatf("start_ovf_L%0d", lanes_of(i)), 64'(ovf[i]), 64'(!g0_legal[i]));
      check_eq($sformatf("start_done_L%0d", lanes_of(i)), 64'(dn[i]), 64'(!g0_legal[i]));
      if (g0_legal[i])
        check_eq($sformatf("start_data_L%0d", lanes_of(i)), dat[i], g0_exp[i]);
    end
    n = 0;
    while (!(dn[0] && dn[1] && dn[2]) && n < max_cyc) begin
      set_ready(mode, n);
      @(posedge clk); #1;
      n++;
    end
    if (full) begin
      check_eq("all_done", {61'd0, dn[2], dn[1], dn[0]}, 64'd7);
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("end_ovf_L%0d", lanes_of(i)), 64'(ovf[i]), 64'd1);
        check_eq($sformatf("end_state_L%0d", lanes_of(i)), 64'(st[i]), 64'd2);
        check_eq($sformatf("end_valid_L%0d", lanes_of(i)), 64'(vld[i]), 64'd0);
        check_eq($sformatf("drained_L%0d", lanes_of(i)), 64'(exp_q[i].size()), 64'd0);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    seed_a = '0;
    seed_b = '0;
    for (int i = 0; i < 3; i++) rdy[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_valid_L%0d", lanes_of(i)), 64'(vld[i]), 64'd0);
      check_eq($sformatf("rst_data_L%0d", lanes_of(i)), dat[i], 64'd0);
      check_eq($sformatf("rst_ovf_L%0d", lanes_of(i)), 64'(ovf[i]), 64'd0);
      check_eq($sformatf("rst_done_L%0d", lanes_of(i)), 64'(dn[i]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Seeds 1,1 at full rate. A restart from DONE follows right after.
    run_seq(16'd1, 16'd1, 0, 300, 1'b1);
    // Backpressure right after the first beat.
    run_seq(16'd1, 16'd1, 2, 300, 1'b1);
    // Random backpressure.
    run_seq(16'd2, 16'd7, 1, 300, 1'b1);
    // Large seeds: an immediate overflow for LANES=4.
    run_seq(16'd40000, 16'd30000, 0, 300, 1'b1);
    // Max-value seeds.
    run_seq(16'hffff, 16'd0, 1, 300, 1'b1);
    // All-zero seeds never finish. Run a while, then restart with a
    // handshake in the same cycle.
    run_seq(16'd0, 16'd0, 1, 30, 1'b0);
    run_seq(16'd1, 16'd1, 0, 3, 1'b0);
    run_seq(16'd3, 16'd4, 0, 300, 1'b1);

    // Asynchronous reset between clock edges while running.
    run_seq(16'd1, 16'd2, 0, 2, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("arst_valid_L%0d", lanes_of(i)), 64'(vld[i]), 64'd0);
      check_eq($sformatf("arst_data_L%0d", lanes_of(i)), dat[i], 64'd0);
      check_eq($sformatf("arst_ovf_L%0d", lanes_of(i)), 64'(ovf[i]), 64'd0);
      check_eq($sformatf("arst_state_L%0d", lanes_of(i)), 64'(st[i]), 64'd0);
      exp_q[i] = {};
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_seq(16'd5, 16'd8, 1, 300, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fibonacci_stream.md
Name: fibonacci_stream

Overview:
Parametrised Fibonacci sequence generator. It emits LANES consecutive terms per accepted beat on a valid/ready stream. It starts from user-supplied seeds and detects overflow at WIDTH bits. It is the multi-lane, seedable, back-pressurable successor to the fixed 1- and 2-term-per-cycle generators, and feeds downstream checkers and stream sinks in the sequential-basics set.

Parameters:
WIDTH, 16, bit width of each term.
LANES, 2, terms emitted per beat; legal values 1..4. Other values are an elaboration error.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  single-cycle pulse; loads seeds and (re)starts the sequence.
seed_a  input  WIDTH  term t0, sampled when start=1.
seed_b  input  WIDTH  term t1, sampled when start=1.
out_valid  output  1  out_data holds a valid group.
out_ready  input  1  downstream accepts the group.
out_data  output  LANES*WIDTH  lane i in bits [i*WIDTH +: WIDTH]; lane 0 holds the lowest-index term.
overflow  output  1  sticky; the next term does not fit in WIDTH bits.
done  output  1  generator has stopped in DONE.

Behaviour:
- Sequence definition: t0=seed_a, t1=seed_b, t(n)=t(n-1)+t(n-2). Group g = terms t(g*LANES) .. t(g*LANES+LANES-1).
- States: IDLE, RUN, DONE.
- Reset (async, any state): IDLE; out_valid=0, out_data=0, overflow=0, done=0.
- Every output is registered; there is no combinational path from any input to any output.
- Internal state: last two terms of the current group (t_hi, t_lo). For LANES=1, t_lo is the term before lane 0.
- Next-group logic: computes LANES candidate terms at WIDTH+1 bits. A group is legal only if every candidate's bit WIDTH is 0.
- start=1 (any state, rst=0):
  - Abandons any pending group.
  - Clears overflow and done.
  - Computes group 0 from the seeds. Lanes 0 and 1 are the seeds; further lanes are sums.
  - If group 0 is legal: next cycle RUN, out_valid=1, out_data=group 0.
  - If group 0 is illegal (possible only for LANES>=3): next cycle DONE, out_valid=0, overflow=1, done=1.
  - Latency start->out_valid is exactly 1 cycle.
- RUN, out_valid & out_ready (handshake):
  - If the next group is legal: load it next cycle; out_valid stays 1. Back-to-back beats run at one group per cycle.
  - If the next group is illegal: next cycle DONE, out_valid=0, overflow=1, done=1. out_data keeps the last group.
- RUN, out_valid & !out_ready: out_data and internal state hold; out_valid stays 1.
- start and handshake in the same cycle: start wins. The handshaken group counts as accepted, but the sequence restarts.
- IDLE/DONE without start: outputs hold. out_ready is ignored.
- Partial groups are never emitted. The final legal group is the last beat.
- Arithmetic: unsigned, wrap-free. No truncated value ever appears on out_data.
- Seeds of 0 are legal. seed_a=seed_b=0 produces all-zero groups forever and never overflows.

Test Plan:
- WIDTH=16, LANES=2, start with seeds 1,1, out_ready=1 -> beats (1,1),(2,3),(5,8),...; 12th beat is (28657,46368); next cycle out_valid=0, overflow=1, done=1.
- WIDTH=16, LANES=4, seeds 1,1 -> first beat (1,1,2,3), 6 beats total, last beat (10946,17711,28657,46368), then DONE with overflow=1. Repeat with LANES=1 -> 24 beats, last value 46368.
- LANES=2, seeds 1,1, out_ready held 0 for 5 cycles after the first beat -> out_data stays (1,1) with out_valid=1 throughout; on release the next beat is (2,3), with no skipped or duplicated groups.
- Seeds 40000,30000: with LANES=2 -> one beat (40000,30000), then DONE with overflow=1. With LANES=4 -> out_valid never rises; overflow=1 and done=1 one cycle after start.
- Assert rst asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately and the state is IDLE. start after reset restarts cleanly from the new seeds.
- start pulsed during RUN, coinciding with a handshake, with seeds 3,4 -> next cycle out_data=(3,4), out_valid=1, overflow=0. start in DONE -> overflow and done clear.
